// File: rtl/cla_slice_sequencer_if.sv
// Operand request / result handshake bundle for cla_slice_sequencer.
// slave is the sequencer side, master is the source/sink side.
interface cla_slice_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             prop_all;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, prop_all
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, prop_all
    );
endinterface

// File: rtl/cla_slice_sequencer.sv
// WIDTH-bit adder built by stepping one external 4-bit CLA slice
// over the operand nibbles LSB-first, rippling carry through a register.
module cla_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_slice_sequencer_if.slave   bus,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic                   slice_cin,
    input  logic [3:0]             slice_sum,
    input  logic                   slice_g,
    input  logic                   slice_p,
    output logic                   busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_slice_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             prop_r;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        busy = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && bus.in_valid;

    // Shifting by idx nibbles keeps the slice select a plain [3:0] pick.
    assign a_sh = a_r >> {idx, 2'b00};
    assign b_sh = b_r >> {idx, 2'b00};

    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        slice_cin = 1'b0;
        if (state == RUN) begin
            slice_a = a_sh[3:0];
            slice_b = b_sh[3:0];
            slice_cin = carry_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            sum_r <= '0;
            carry_r <= 1'b0;
            prop_r <= 1'b0;
            idx <= '0;
        end else if (accept) begin
            a_r <= bus.a;
            b_r <= bus.b;
            carry_r <= bus.cin;
            prop_r <= 1'b1;
            idx <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NSLICE; i++) begin
                if (idx == IW'(i)) sum_r[4*i +: 4] <= slice_sum;
            end
            carry_r <= slice_g | (slice_p & carry_r);
            prop_r <= prop_r & slice_p;
            if (idx != LAST) idx <= idx + 1'b1;
        end
    end

    assign bus.sum = sum_r;
    assign bus.cout = carry_r;
    assign bus.prop_all = prop_r;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Scoreboard bench for cla_slice_sequencer at WIDTH=16 and WIDTH=4,
// each paired with a behavioural 4-bit CLA slice.
module tb_cla_slice_sequencer;
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        p;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    exp_t q16[$];
    exp_t q4[$];

    cla_slice_sequencer_if #(.WIDTH(16)) bus16 ();
    cla_slice_sequencer_if #(.WIDTH(4))  bus4 ();

    logic [3:0] sa16, sb16, ss16, sa4, sb4, ss4;
    logic       sc16, sg16, sp16, bz16, sc4, sg4, sp4, bz4;
    logic [4:0] t16, t4;

    cla_slice_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16),
        .slice_a(sa16), .slice_b(sb16), .slice_cin(sc16),
        .slice_sum(ss16), .slice_g(sg16), .slice_p(sp16),
        .busy(bz16)
    );

    cla_slice_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .slice_a(sa4), .slice_b(sb4), .slice_cin(sc4),
        .slice_sum(ss4), .slice_g(sg4), .slice_p(sp4),
        .busy(bz4)
    );

    assign t16 = {1'b0, sa16} + {1'b0, sb16} + {4'b0, sc16};
    assign ss16 = t16[3:0];
    assign sg16 = ({1'b0, sa16} + {1'b0, sb16}) > 5'd15;
    assign sp16 = &(sa16 ^ sb16);
    assign t4 = {1'b0, sa4} + {1'b0, sb4} + {4'b0, sc4};
    assign ss4 = t4[3:0];
    assign sg4 = ({1'b0, sa4} + {1'b0, sb4}) > 5'd15;
    assign sp4 = &(sa4 ^ sb4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;
        bus16.cin = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0;
        bus4.cin = 1'b0; bus4.out_ready = 1'b0;
        #12;
        total++;
        if ({bus16.out_valid, bz16, bus16.in_ready, bus16.sum,
             bus16.cout, bus16.prop_all, sa16, sc16} !== {3'b001, 16'h0, 2'b0, 4'h0, 1'b0})
            $display("FAIL reset16: got ov=%b busy=%b ir=%b sum=%h c=%b p=%b",
                     bus16.out_valid, bz16, bus16.in_ready, bus16.sum,
                     bus16.cout, bus16.prop_all);
        else passed++;
        total++;
        if ({bus4.out_valid, bz4, bus4.in_ready, bus4.sum} !== {3'b001, 4'h0})
            $display("FAIL reset4: got ov=%b busy=%b ir=%b sum=%h want 0 0 1 0",
                     bus4.out_valid, bz4, bus4.in_ready, bus4.sum);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_op16(input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input int hold);
        exp_t e;
        exp_t got;
        logic [3:0] cexp;
        logic [4:0] s;
        logic c;
        logic [16:0] full;
        int waited;
        c = cv;
        for (int i = 0; i < 4; i++) begin
            cexp[i] = c;
            s = {1'b0, av[4*i +: 4]} + {1'b0, bv[4*i +: 4]} + {4'b0, c};
            c = s[4];
        end
        full = {1'b0, av} + {1'b0, bv} + {16'b0, cv};
        e.s = full[15:0];
        e.c = full[16];
        e.p = &(av ^ bv);
        q16.push_back(e);
        @(negedge clk);
        total++;
        if (bus16.in_ready !== 1'b1)
            $display("FAIL in_ready_idle: got %b want 1", bus16.in_ready);
        else passed++;
        bus16.in_valid = 1'b1; bus16.a = av; bus16.b = bv; bus16.cin = cv;
        @(posedge clk);
        #1 bus16.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({sa16, sb16, sc16, bus16.out_valid, bz16, bus16.in_ready} !==
                {av[4*i +: 4], bv[4*i +: 4], cexp[i], 3'b010})
                $display("FAIL run_step%0d: got a=%h b=%h cin=%b ov=%b want a=%h b=%h cin=%b ov=0",
                         i, sa16, sb16, sc16, bus16.out_valid,
                         av[4*i +: 4], bv[4*i +: 4], cexp[i]);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (bus16.out_valid !== 1'b1) begin
            $display("FAIL latency16: out_valid=%b want 1 after 4 RUN cycles", bus16.out_valid);
            waited = 0;
            while (bus16.out_valid !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (bus16.out_valid !== 1'b1) begin
                total++;
                $display("FAIL timeout16: out_valid never rose");
                void'(q16.pop_front());
                return;
            end
        end else passed++;
        got = q16.pop_front();
        for (int h = 0; h < hold; h++) begin
            bus16.in_valid = (h == 1 || h == 2);
            bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.cin = 1'b1;
            @(negedge clk);
            total++;
            if ({bus16.out_valid, bus16.in_ready, bus16.sum, bus16.cout} !==
                {2'b10, got.s, got.c})
                $display("FAIL hold%0d: got ov=%b ir=%b sum=%h c=%b want 1 0 %h %b",
                         h, bus16.out_valid, bus16.in_ready, bus16.sum,
                         bus16.cout, got.s, got.c);
            else passed++;
        end
        bus16.in_valid = 1'b0;
        total++;
        if ({bus16.sum, bus16.cout, bus16.prop_all} !== {got.s, got.c, got.p})
            $display("FAIL result16: got sum=%h c=%b p=%b want sum=%h c=%b p=%b",
                     bus16.sum, bus16.cout, bus16.prop_all, got.s, got.c, got.p);
        else passed++;
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1 bus16.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus16.out_valid, bus16.in_ready, bz16} !== 3'b010)
            $display("FAIL handoff16: got ov=%b ir=%b busy=%b want 0 1 0",
                     bus16.out_valid, bus16.in_ready, bz16);
        else passed++;
    endtask

    task automatic test_basic;
        do_op16(16'h1234, 16'h4321, 1'b0, 0);
        do_op16(16'hFFFF, 16'h0000, 1'b1, 0);
        do_op16(16'h8000, 16'h8000, 1'b0, 0);
    endtask

    task automatic test_backpressure;
        do_op16(16'h0F0F, 16'h0101, 1'b1, 5);
        do_op16(16'h7777, 16'h1111, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++)
            do_op16(16'($urandom), 16'($urandom), 1'($urandom), k % 2);
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        bus16.in_valid = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0;
        @(posedge clk);
        #1 bus16.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus16.out_valid, bz16, bus16.in_ready, bus16.sum, bus16.cout} !==
            {3'b001, 16'h0, 1'b0})
            $display("FAIL reset_midrun: got ov=%b busy=%b ir=%b sum=%h c=%b want 0 0 1 0000 0",
                     bus16.out_valid, bz16, bus16.in_ready, bus16.sum, bus16.cout);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        do_op16(16'h0001, 16'h0001, 1'b0, 0);
    endtask

    task automatic test_width4;
        exp_t e;
        exp_t got;
        logic [4:0] f;
        f = 5'hF + 5'h1;
        e.s = {12'h0, f[3:0]};
        e.c = f[4];
        e.p = &(4'hF ^ 4'h1);
        q4.push_back(e);
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.a = 4'hF; bus4.b = 4'h1; bus4.cin = 1'b0;
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({sa4, sb4, bus4.out_valid, bz4} !== {4'hF, 4'h1, 2'b01})
            $display("FAIL run4: got a=%h b=%h ov=%b busy=%b want f 1 0 1",
                     sa4, sb4, bus4.out_valid, bz4);
        else passed++;
        @(negedge clk);
        got = q4.pop_front();
        total++;
        if ({bus4.out_valid, bus4.sum, bus4.cout, bus4.prop_all} !==
            {1'b1, got.s[3:0], got.c, got.p})
            $display("FAIL result4: got ov=%b sum=%h c=%b p=%b want 1 %h %b %b",
                     bus4.out_valid, bus4.sum, bus4.cout, bus4.prop_all,
                     got.s[3:0], got.c, got.p);
        else passed++;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1 bus4.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus4.out_valid, bus4.in_ready} !== 2'b01)
            $display("FAIL handoff4: got ov=%b ir=%b want 0 1", bus4.out_valid, bus4.in_ready);
        else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset;
        test_basic;
        test_backpressure;
        test_reset_midrun;
        test_back_to_back;
        test_width4;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
Multi-cycle controller that performs a WIDTH-bit addition by time-sharing one external 4-bit CLA slice. The slice supplies sum, group generate and group propagate. The block steps the slice over the operand nibbles LSB-first and ripples the carry through a register. It also accumulates the whole-word propagate. It sits between a valid/ready operand source and a valid/ready result sink.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error
NSLICE, WIDTH/4, derived number of slice steps; not overridable

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
slice_a  output  4  nibble of A to CLA slice
slice_b  output  4  nibble of B to CLA slice
slice_cin  output  1  carry into CLA slice
slice_sum  input  4  slice sum (combinational, same cycle)
slice_g  input  1  slice group generate
slice_p  input  1  slice group propagate
out_valid  output  1  result available
out_ready  input  1  sink accepts result
sum  output  WIDTH  result sum
cout  output  1  final carry-out
prop_all  output  1  AND of all slice propagates (word propagate)
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a, b and cin into a_r, b_r and carry_r, set idx=0, prop_r=1, and go to RUN.
  - RUN: in_ready=0. Each cycle:
    - drive slice_a=a_r[4*idx+:4], slice_b=b_r[4*idx+:4], slice_cin=carry_r;
    - on the clock edge, write sum_r[4*idx+:4]<=slice_sum;
    - carry_r<=slice_g | (slice_p & carry_r);
    - prop_r<=prop_r & slice_p;
    - idx<=idx+1.
    - When idx==NSLICE-1, go to DONE instead of incrementing.
  - DONE: out_valid=1. sum, cout and prop_all are held stable. in_ready=0; in_valid is ignored. On out_ready, go to IDLE.
- The slice carry rule uses slice_g and slice_p only. slice_sum must already reflect slice_cin.
- Outside RUN, slice_a, slice_b and slice_cin are driven to 0.
- idx width is clog2(NSLICE), minimum 1 bit. idx never wraps past NSLICE-1.
- Latency and throughput:
  - Operands accepted at edge k give out_valid high after edge k+NSLICE.
  - Minimum initiation interval is NSLICE+2 cycles. There is no accept in the same cycle as result handoff.
- sum, cout and prop_all are registered outputs (sum_r, carry_r, prop_r). They are valid only while out_valid=1. In other states their value is don't-care for the sink but deterministic.
- Reset, asserted at any time and in any state, forces:
  - state=IDLE; idx=0;
  - a_r, b_r, sum_r, carry_r = 0; prop_r = 0;
  - out_valid=0; busy=0; in_ready=1.
- Reset mid-RUN or mid-DONE aborts the operation silently. No partial result is ever presented.
- WIDTH=4: RUN lasts exactly one cycle.
- out_ready high outside DONE has no effect.
- A handshake in DONE completes in the cycle out_valid & out_ready. out_valid is low in the next cycle.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, prop_all=0. out_valid rises 4 cycles after accept; slice_a sequence is 4,3,2,1.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, prop_all=1. slice_cin=1 on all four RUN cycles.
- a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, prop_all=0. slice_cin=0 on the first three steps.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands -> sum, cout and out_valid stay unchanged, in_ready stays 0, and the new operands are not captured. After out_ready=1 the block returns to IDLE and accepts the next request.
- Reset after 2 RUN cycles of a=0xFFFF, b=0x0001 -> out_valid stays 0, busy=0, in_ready=1 immediately. A following op a=0x0001, b=0x0001 gives sum=0x0002, cout=0.
- WIDTH=4, a=0xF, b=0x1, cin=0 -> sum=0x0, cout=1, prop_all=0. out_valid one cycle after accept.
